// File: rtl/sd_blk_tx.sv
// SD DAT0 block transmitter: streams a buffer RAM onto the line as start bit, data, CRC16, end bit.
// Optional CRC16 generation is enabled with macro SD_BLK_TX_CRC_EN.
module sd_blk_tx #(
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned BLK_BYTES = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_en,
    output logic [ADDR_BITS-1:0] ram_addr,
    input  logic [7:0]           ram_data,
    output logic                 dat_out,
    output logic                 dat_oe,
    output logic                 busy,
    output logic                 done
);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(BLK_BYTES - 1);
`ifdef SD_BLK_TX_CRC_EN
    localparam logic [15:0] CRC_POLY = 16'h1021;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef SD_BLK_TX_CRC_EN
        S_CRC   = 3'd3,
`endif
        S_STOP  = 3'd4,
        S_REL   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 last_q, last_d;
    logic                 dat_out_q, dat_out_d;
    logic                 dat_oe_q, dat_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef SD_BLK_TX_CRC_EN
    logic [15:0]          crc_q, crc_d;
`endif

    // The address stops at the last byte so it never wraps before release.
    logic                 load_last_c;
    logic [ADDR_BITS-1:0] addr_inc_c;
    assign load_last_c = (addr_q == LAST_ADDR);
    assign addr_inc_c  = load_last_c ? addr_q : addr_q + ADDR_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            dat_out_q <= 1'b1;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SD_BLK_TX_CRC_EN
            crc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            dat_out_q <= dat_out_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SD_BLK_TX_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        dat_out_d = dat_out_q;
        dat_oe_d  = dat_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SD_BLK_TX_CRC_EN
        crc_d     = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    last_d  = 1'b0;
`ifdef SD_BLK_TX_CRC_EN
                    crc_d   = '0;
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_en) begin
                    dat_out_d = 1'b0;
                    dat_oe_d  = 1'b1;
                    shreg_d   = ram_data;
                    last_d    = load_last_c;
                    addr_d    = addr_inc_c;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    dat_out_d = shreg_q[7];
`ifdef SD_BLK_TX_CRC_EN
                    crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ shreg_q[7]) ? CRC_POLY : 16'h0000);
`endif
                    if (bit_cnt_q != 4'd7) begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        bit_cnt_d = '0;
                        if (last_q) begin
`ifdef SD_BLK_TX_CRC_EN
                            state_d = S_CRC;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            shreg_d = ram_data;
                            last_d  = load_last_c;
                            addr_d  = addr_inc_c;
                        end
                    end
                end
            end
`ifdef SD_BLK_TX_CRC_EN
            S_CRC: begin
                if (bit_en) begin
                    dat_out_d = crc_q[15];
                    crc_d     = {crc_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (bit_en) begin
                    dat_out_d = 1'b1;
                    state_d   = S_REL;
                end
            end
            S_REL: begin
                if (bit_en) begin
                    dat_oe_d  = 1'b0;
                    dat_out_d = 1'b1;
                    addr_d    = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ram_addr = addr_q;
    assign dat_out  = dat_out_q;
    assign dat_oe   = dat_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sd_blk_tx.sv
// Self-checking bench for sd_blk_tx: captured DAT0 frames are compared with a frame built from the buffer contents.
module tb_sd_blk_tx;
    localparam int unsigned ADDR_BITS = 9;
    localparam int unsigned BLK_BYTES = 512;
`ifdef SD_BLK_TX_CRC_EN
    localparam int CRC_BITS = 16;
`else
    localparam int CRC_BITS = 0;
`endif
    localparam int FRAME_STROBES = 1 + 8 * BLK_BYTES + CRC_BITS + 2;
    localparam int LINE_BITS     = FRAME_STROBES - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 bit_en = 1'b0;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [7:0]           ram_data;
    logic                 dat_out, dat_oe, busy, done;

    logic [7:0] mem [BLK_BYTES];
    int checks = 0;
    int errors = 0;
    bit capq[$];
    bit expq[$];
    int strobes, addr_bad, max_addr, done_bad, busy_bad;
    bit got_done;

    sd_blk_tx #(.ADDR_BITS(ADDR_BITS), .BLK_BYTES(BLK_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_en(bit_en),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .dat_out(dat_out), .dat_oe(dat_oe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Buffer RAM with one-cycle registered read.
    always @(posedge clk) ram_data <= mem[ram_addr];

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        for (int i = 0; i < int'(BLK_BYTES); i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ mem[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic void build_expected();
        logic [15:0] c;
        expq.delete();
        expq.push_back(1'b0);
        for (int i = 0; i < int'(BLK_BYTES); i++)
            for (int b = 7; b >= 0; b--) expq.push_back(mem[i][b]);
        c = model_crc();
        if (CRC_BITS > 0)
            for (int b = 15; b >= 0; b--) expq.push_back(c[b]);
        expq.push_back(1'b1);
    endfunction

    function automatic int first_diff();
        if (capq.size() != expq.size()) return 0;
        foreach (capq[i]) if (capq[i] !== expq[i]) return i;
        return -1;
    endfunction

    // Drives one frame; bit_en pattern per mode (0 continuous, 1 every 3rd clk, 2 random).
    task automatic run_frame(input int mode, input int es1, input int es2, input int abort_at);
        int cyc;
        bit be;
        logic [ADDR_BITS-1:0] prev_addr;
        cyc = 0;
        capq.delete();
        strobes = 0; got_done = 0; addr_bad = 0; max_addr = 0; done_bad = 0; busy_bad = 0;
        prev_addr = ram_addr;
        start  = 1'b1;
        bit_en = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        if (!busy) busy_bad++;
        while (!got_done && cyc < 20000) begin
            case (mode)
                0:       be = 1'b1;
                1:       be = (cyc % 3 == 2);
                default: be = ($urandom_range(0, 3) != 0);
            endcase
            bit_en = be;
            start  = (strobes == es1 || strobes == es2);
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (be) strobes++;
            if (abort_at >= 0 && strobes == abort_at) begin
                bit_en = 1'b0;
                return;
            end
            if (be && dat_oe) capq.push_back(dat_out);
            if (!done) begin
                if (ram_addr != prev_addr && int'(ram_addr) != int'(prev_addr) + 1) addr_bad++;
                if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
                if (!busy) busy_bad++;
            end
            prev_addr = ram_addr;
            if (done) begin
                got_done = 1'b1;
                if (!be) done_bad++;
            end
        end
        bit_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dat_out !== 1'b1) begin errors++; $display("FAIL reset_dat_out: got %b want 1", dat_out); end
        checks++; if (dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", dat_oe); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_ones();
        logic [15:0] crc_seen;
        int d;
        foreach (mem[i]) mem[i] = 8'hFF;
        build_expected();
        run_frame(0, -1, -1, -1);
        checks++; if (!got_done || strobes != FRAME_STROBES) begin errors++; $display("FAIL ones_strobes: got %0d (done=%0b) want %0d", strobes, got_done, FRAME_STROBES); end
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL ones_stream: size %0d want %0d, first diff at %0d", capq.size(), expq.size(), d); end
        crc_seen = 16'hxxxx;
`ifdef SD_BLK_TX_CRC_EN
        if (capq.size() >= LINE_BITS)
            for (int k = 0; k < 16; k++) crc_seen[15-k] = capq[1 + 8*BLK_BYTES + k];
        checks++; if (crc_seen !== 16'h7FA1) begin errors++; $display("FAIL ones_crc: got %h want 7fa1", crc_seen); end
`else
        checks++; if (capq.size() != LINE_BITS || capq[1 + 8*BLK_BYTES] !== 1'b1) begin errors++; $display("FAIL ones_endbit: size %0d want %0d", capq.size(), LINE_BITS); end
`endif
        checks++; if (dat_oe !== 1'b0 || busy !== 1'b0 || dat_out !== 1'b1) begin errors++; $display("FAIL ones_release: oe=%b busy=%b out=%b want 0 0 1", dat_oe, busy, dat_out); end
        checks++; if (done_bad != 0 || busy_bad != 0) begin errors++; $display("FAIL ones_flags: done_bad=%0d busy_bad=%0d want 0 0", done_bad, busy_bad); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ones_done_width: got %b want 0", done); end
    endtask

    task automatic test_all_zero();
        int d;
        foreach (mem[i]) mem[i] = 8'h00;
        build_expected();
        run_frame(0, -1, -1, -1);
        d = first_diff();
        checks++; if (!got_done || d >= 0) begin errors++; $display("FAIL zero_stream: done=%0b size %0d want %0d, diff at %0d", got_done, capq.size(), expq.size(), d); end
        checks++; if (addr_bad != 0 || max_addr != int'(BLK_BYTES) - 1) begin errors++; $display("FAIL zero_addr_seq: bad steps %0d max %0d want 0 %0d", addr_bad, max_addr, BLK_BYTES - 1); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL zero_addr_after: got %0d want 0", ram_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_slow_bit_en();
        bit slowq[$];
        int d;
        foreach (mem[i]) mem[i] = 8'(i);
        build_expected();
        run_frame(1, -1, -1, -1);
        d = first_diff();
        checks++; if (!got_done || strobes != FRAME_STROBES || d >= 0) begin errors++; $display("FAIL slow_stream: strobes %0d want %0d, size %0d want %0d, diff at %0d", strobes, FRAME_STROBES, capq.size(), expq.size(), d); end
        checks++; if (done_bad != 0) begin errors++; $display("FAIL slow_done_align: got %0d want 0", done_bad); end
        slowq = capq;
        @(posedge clk); #1;
        run_frame(0, -1, -1, -1);
        checks++; if (slowq != capq) begin errors++; $display("FAIL slow_vs_fast: sizes %0d %0d differ in content", slowq.size(), capq.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int d, bad;
        foreach (mem[i]) mem[i] = 8'($urandom);
        build_expected();
        run_frame(0, 1000, FRAME_STROBES - 1, -1);
        d = first_diff();
        checks++; if (!got_done || strobes != FRAME_STROBES || d >= 0) begin errors++; $display("FAIL restart_stream: strobes %0d want %0d, diff at %0d", strobes, FRAME_STROBES, d); end
        bad = 0;
        bit_en = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || dat_oe || done) bad++;
        end
        bit_en = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL restart_extra_frame: %0d active cycles want 0", bad); end
    endtask

    task automatic test_abort();
        int d;
        foreach (mem[i]) mem[i] = 8'($urandom);
        run_frame(0, -1, -1, 1 + 8*100);
        rst_n = 1'b0;
        #1;
        checks++; if (dat_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_outputs: oe=%b busy=%b done=%b want 000", dat_oe, busy, done); end
        checks++; if (ram_addr !== '0 || dat_out !== 1'b1) begin errors++; $display("FAIL abort_addr_line: addr=%0d out=%b want 0 1", ram_addr, dat_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        foreach (mem[i]) mem[i] = 8'($urandom);
        build_expected();
        run_frame(2, -1, -1, -1);
        d = first_diff();
        checks++; if (!got_done || strobes != FRAME_STROBES || d >= 0) begin errors++; $display("FAIL abort_next_frame: strobes %0d want %0d, diff at %0d", strobes, FRAME_STROBES, d); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 2; it++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            build_expected();
            run_frame(2, -1, -1, -1);
            d = first_diff();
            checks++; if (!got_done || strobes != FRAME_STROBES || d >= 0) begin errors++; $display("FAIL random_stream_%0d: strobes %0d want %0d, diff at %0d", it, strobes, FRAME_STROBES, d); end
            checks++; if (done_bad != 0 || busy_bad != 0 || addr_bad != 0) begin errors++; $display("FAIL random_flags_%0d: done_bad %0d busy_bad %0d addr_bad %0d want 0", it, done_bad, busy_bad, addr_bad); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zero();
        test_slow_bit_en();
        test_start_ignored();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
